// File: rtl/serial_deserializer.sv
// Serial-in parallel-out receiver: MSB-first WIDTH-bit frames, optional even parity,
// result held in a valid/ready output register with sticky overrun.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             start,
    input  logic             data_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic             done;
    logic             load;

    assign shifted = {shreg_q[WIDTH-2:0], sin};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        done      = 1'b0;
        word      = '0;
        word_perr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d = '0;
                    if (PARITY_EN) begin
                        state_d = PARITY;
                    end else begin
                        state_d = IDLE;
                        done    = 1'b1;
                        word    = shifted;
                    end
                end
            end
            PARITY: begin
                state_d   = IDLE;
                done      = 1'b1;
                word      = shreg_q;
                word_perr = (^shreg_q) ^ sin;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A word completing while the register is full is kept only if the consumer takes the old one now.
    always_comb begin
        load    = done && (!valid_q || data_ready);
        data_d  = data_q;
        perr_d  = perr_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            data_d  = word;
            perr_d  = word_perr;
            valid_d = 1'b1;
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        if (done && !load) begin
            ovr_d = 1'b1;
        end else if (clear) begin
            ovr_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: one instance without parity, one with parity.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sin = 1'b0;
    logic       start = 1'b0;
    logic       data_ready = 1'b0;
    logic       clear = 1'b0;

    logic [7:0] d0, d1;
    logic       v0, v1, pe0, pe1, ov0, ov1, b0, b1;

    int checks = 0;
    int errors = 0;
    int bcnt0, bcnt1;
    logic vdrop0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(8), .PARITY_EN(1'b0)) u0 (
        .clk(clk), .reset(reset), .sin(sin), .start(start), .data_ready(data_ready),
        .clear(clear), .data_out(d0), .data_valid(v0), .parity_err(pe0),
        .overrun(ov0), .busy(b0)
    );

    serial_deserializer #(.WIDTH(8), .PARITY_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .sin(sin), .start(start), .data_ready(data_ready),
        .clear(clear), .data_out(d1), .data_valid(v1), .parity_err(pe1),
        .overrun(ov1), .busy(b1)
    );

    typedef struct {
        logic       pe;
        logic [8:0] bits;
        int         n;
        logic [7:0] exp_d;
        logic       exp_perr;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Sends bits[n-1] first; start also pulses at index restart_at (ignored mid-frame).
    task automatic send_frame(input logic [8:0] bits, input int n, input logic rdy_last,
                              input int restart_at);
        logic rdy_rest;
        rdy_rest = data_ready;
        bcnt0 = 0;
        bcnt1 = 0;
        vdrop0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            start = (i == 0) || (i == restart_at);
            sin = bits[n-1-i];
            data_ready = (i == n - 1) ? rdy_last : rdy_rest;
            tick();
            if (b0) bcnt0++;
            if (b1) bcnt1++;
            if (!v0) vdrop0 = 1'b1;
        end
        start = 1'b0;
        sin = 1'b0;
        data_ready = rdy_rest;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 9'h0A5, 8, 8'hA5, 1'b0};
        vecs[1]  = '{1'b0, 9'h03C, 8, 8'h3C, 1'b0};
        vecs[2]  = '{1'b0, 9'h0FF, 8, 8'hFF, 1'b0};
        vecs[3]  = '{1'b0, 9'h001, 8, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 9'h080, 8, 8'h80, 1'b0};
        vecs[5]  = '{1'b0, 9'h000, 8, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, {8'h81, 1'b0}, 9, 8'h81, 1'b0};
        vecs[7]  = '{1'b1, {8'h81, 1'b1}, 9, 8'h81, 1'b1};
        vecs[8]  = '{1'b1, {8'h7F, 1'b1}, 9, 8'h7F, 1'b0};
        vecs[9]  = '{1'b1, {8'h7F, 1'b0}, 9, 8'h7F, 1'b1};
        vecs[10] = '{1'b1, {8'hC3, 1'b1}, 9, 8'hC3, 1'b1};

        #1;
        chk("rst_data0", d0, 0);
        chk("rst_valid0", v0, 0);
        chk("rst_busy0", b0, 0);
        chk("rst_ovr1", ov1, 0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 11; k++) begin
            do_reset();
            data_ready = 1'b1;
            send_frame(vecs[k].bits, vecs[k].n, 1'b1, -1);
            if (vecs[k].pe) begin
                chk($sformatf("vec%0d_data", k), d1, vecs[k].exp_d);
                chk($sformatf("vec%0d_valid", k), v1, 1);
                chk($sformatf("vec%0d_perr", k), pe1, vecs[k].exp_perr);
                chk($sformatf("vec%0d_busy", k), bcnt1, 8);
            end else begin
                chk($sformatf("vec%0d_data", k), d0, vecs[k].exp_d);
                chk($sformatf("vec%0d_valid", k), v0, 1);
                chk($sformatf("vec%0d_perr", k), pe0, 0);
                chk($sformatf("vec%0d_busy", k), bcnt0, 7);
            end
        end

        // Single frame: valid pulses one cycle with the consumer always ready
        do_reset();
        data_ready = 1'b1;
        send_frame(9'h0A5, 8, 1'b1, -1);
        chk("a5_data", d0, 8'hA5);
        chk("a5_valid", v0, 1);
        chk("a5_busy_cycles", bcnt0, 7);
        chk("a5_busy_after", b0, 0);
        tick();
        chk("a5_valid_pulse", v0, 0);

        // Zero-gap frames with no consumer: second word dropped
        do_reset();
        data_ready = 1'b0;
        send_frame(9'h03C, 8, 1'b0, -1);
        chk("ov_first_data", d0, 8'h3C);
        chk("ov_first_ovr", ov0, 0);
        send_frame(9'h0FF, 8, 1'b0, -1);
        chk("ov_data", d0, 8'h3C);
        chk("ov_valid_held", vdrop0, 0);
        chk("ov_ovr", ov0, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovr", ov0, 0);
        chk("clr_data", d0, 8'h3C);
        chk("clr_valid", v0, 1);

        // Consumer accepts on the second completion edge: swap without a valid gap
        do_reset();
        data_ready = 1'b0;
        send_frame(9'h03C, 8, 1'b0, -1);
        send_frame(9'h0FF, 8, 1'b1, -1);
        chk("swap_data", d0, 8'hFF);
        chk("swap_valid_cont", vdrop0, 0);
        chk("swap_valid", v0, 1);
        chk("swap_ovr", ov0, 0);

        // Parity instance, back-to-back frames
        do_reset();
        data_ready = 1'b1;
        send_frame({8'h81, 1'b0}, 9, 1'b1, -1);
        chk("par0_data", d1, 8'h81);
        chk("par0_perr", pe1, 0);
        chk("par0_busy", bcnt1, 8);
        send_frame({8'h81, 1'b1}, 9, 1'b1, -1);
        chk("par1_data", d1, 8'h81);
        chk("par1_perr", pe1, 1);
        chk("par1_valid", v1, 1);
        chk("par1_ovr", ov1, 0);

        // Asynchronous reset mid-frame (u0 still holds FF from a prior load)
        do_reset();
        data_ready = 1'b1;
        send_frame(9'h0FF, 8, 1'b1, -1);
        data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = (i == 0);
            sin = (i == 0 || i == 2);
            tick();
        end
        start = 1'b0;
        chk("ar_pre_busy", b0, 1);
        chk("ar_pre_data", d0, 8'hFF);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_data", d0, 0);
        chk("ar_valid", v0, 0);
        chk("ar_busy", b0, 0);
        chk("ar_perr1", pe1, 0);
        #2;
        reset = 1'b0;
        data_ready = 1'b1;
        send_frame(9'h05A, 8, 1'b1, -1);
        chk("ar_fresh_data", d0, 8'h5A);
        chk("ar_fresh_ovr", ov0, 0);

        // start during a frame is ignored; then a frame of all zeros
        do_reset();
        data_ready = 1'b1;
        send_frame(9'h0C3, 8, 1'b1, 3);
        chk("restart_data", d0, 8'hC3);
        send_frame(9'h000, 8, 1'b1, -1);
        chk("zero_data", d0, 8'h00);
        chk("zero_valid", v0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
